// File: rtl/accumulator_bank.sv
// Time-multiplexed bank of signed accumulators with a shared pre-add chain,
// optional saturation and a read(-and-clear) port.
module accumulator_bank #(
  parameter  int SIZEIN   = 16,
  parameter  int ACC_W    = 33,
  parameter  int N_CH     = 8,
  parameter  int SATURATE = 1,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     in_first,
  input  logic signed [SIZEIN-1:0] a,
  input  logic signed [SIZEIN-1:0] b,
  input  logic                     rd_req,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic                     rd_clr,
  output logic                     rd_valid,
  output logic [ACC_W-1:0]         rd_data,
  output logic                     ovf
);

  localparam int SW = SIZEIN + 1;

  logic                     w_flush;
  logic signed [SIZEIN-1:0] r_s1_a;
  logic signed [SIZEIN-1:0] r_s1_b;
  logic [CH_W-1:0]          r_s1_ch;
  logic                     r_s1_first;
  logic                     r_s1_vld;
  logic signed [SW-1:0]     r_s2_sum;
  logic [CH_W-1:0]          r_s2_ch;
  logic                     r_s2_first;
  logic                     r_s2_vld;
  logic [ACC_W-1:0]         r_acc [N_CH];
  logic                     r_ovf;
  logic                     r_rdq_vld;
  logic [ACC_W-1:0]         r_rdq_data;
  logic                     r_rd_vld;
  logic [ACC_W-1:0]         r_rd_data;

  logic                     w_s3_hit;
  logic                     w_rd_ok;
  logic                     w_rd_clr;
  logic                     w_clr_hit;
  logic [ACC_W-1:0]         w_base;
  logic [ACC_W:0]           w_exact;
  logic                     w_ovf;
  logic [ACC_W-1:0]         w_new;
  logic [ACC_W-1:0]         w_max;
  logic [ACC_W-1:0]         w_min;

  assign w_flush = rst | clear;
  assign w_max   = {1'b0, {(ACC_W-1){1'b1}}};
  assign w_min   = {1'b1, {(ACC_W-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_ch    <= '0;
      r_s2_sum   <= '0;
    end else begin
      r_s1_vld   <= in_valid;
      r_s1_first <= in_first;
      r_s1_ch    <= in_ch;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_ch    <= r_s1_ch;
      r_s2_sum   <= {r_s1_a[SIZEIN-1], r_s1_a}
                  + {r_s1_b[SIZEIN-1], r_s1_b};
    end
  end

  // A same-edge read-clear zeroes the base so the landing sample survives.
  always_comb begin
    w_s3_hit  = r_s2_vld && (int'(r_s2_ch) < N_CH);
    w_rd_ok   = int'(rd_ch) < N_CH;
    w_rd_clr  = rd_req && rd_clr && w_rd_ok;
    w_clr_hit = w_rd_clr && (rd_ch == r_s2_ch);
    w_base    = '0;
    if (w_s3_hit && !r_s2_first && !w_clr_hit)
      w_base = r_acc[r_s2_ch];
    w_exact = {w_base[ACC_W-1], w_base}
            + {{(ACC_W+1-SW){r_s2_sum[SW-1]}}, r_s2_sum};
    w_ovf   = w_exact[ACC_W] ^ w_exact[ACC_W-1];
    w_new   = w_exact[ACC_W-1:0];
    if (w_ovf && (SATURATE != 0))
      w_new = w_exact[ACC_W] ? w_min : w_max;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int i = 0; i < N_CH; i++)
        r_acc[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_rd_clr)
        r_acc[rd_ch] <= '0;
      if (w_s3_hit) begin
        r_acc[r_s2_ch] <= w_new;
        if (w_ovf)
          r_ovf <= 1'b1;
      end
    end
  end

  // Capture is read-before-write; the second register presents the result.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_rdq_vld  <= 1'b0;
      r_rdq_data <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rdq_vld  <= rd_req;
      r_rdq_data <= (rd_req && w_rd_ok) ? r_acc[rd_ch] : '0;
      r_rd_vld   <= r_rdq_vld;
      r_rd_data  <= r_rdq_data;
    end
  end

  assign rd_valid = r_rd_vld;
  assign rd_data  = r_rd_data;
  assign ovf      = r_ovf;

endmodule
